// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit in-order core.
//
// Contents:
//   - register index / data widths
//   - ALU command width and codes
//   - branch type encodings
//   - id_ex_ctrl_t: packed decoded control bundle carried from ID to EX
//   - slot_match(): a pipeline slot produces a value a source register needs
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int ALU_CMD_W = 4;

    localparam logic [ALU_CMD_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_CMD_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_CMD_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_CMD_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_CMD_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALU_CMD_W-1:0] ALU_SLL = 4'b0101;
    localparam logic [ALU_CMD_W-1:0] ALU_SRL = 4'b0110;
    localparam logic [ALU_CMD_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] BR_JMP = 2'b00;
    localparam logic [1:0] BR_BEZ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;

    typedef struct packed {
        logic [ALU_CMD_W-1:0] alu_cmd;
        logic                 mem_read;
        logic                 mem_write;
        logic                 wb_en;
        logic                 is_imm;
        logic                 is_branch;
        logic [1:0]           branch_type;
    } id_ex_ctrl_t;

    // r0 is hardwired to zero, so a write to it never feeds anybody.
    function automatic logic slot_match(input logic                 slot_v,
                                        input logic                 slot_wb,
                                        input logic [REG_IDX_W-1:0] slot_dest,
                                        input logic [REG_IDX_W-1:0] src);
        return slot_v & slot_wb & (slot_dest == src) & (src != '0);
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// hazard_detect: combinational RAW check of the ID sources against the EX
// slot and the shadow MEM slot.
//
// Ports:
//   src1, src2, uses_src2          ID source registers; src2 only if read
//   ex_v, ex_wb, ex_mem_read,
//   ex_dest                        instruction currently in EX
//   mem_v, mem_wb, mem_dest        shadow of the instruction now in MEM
//   hazard                         ID must not advance this cycle
//
// With FORWARD_EN=1 only a load in EX can't be bypassed (its data arrives
// after EX needs it); everything else is forwarded downstream.
module hazard_detect
    import cpu_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 uses_src2,
    input  logic                 ex_v,
    input  logic                 ex_wb,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_dest,
    input  logic                 mem_v,
    input  logic                 mem_wb,
    input  logic [REG_IDX_W-1:0] mem_dest,
    output logic                 hazard
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit  = slot_match(ex_v, ex_wb, ex_dest, src1)
                | (uses_src2 & slot_match(ex_v, ex_wb, ex_dest, src2));
        mem_hit = slot_match(mem_v, mem_wb, mem_dest, src1)
                | (uses_src2 & slot_match(mem_v, mem_wb, mem_dest, src2));
        hazard  = FORWARD_EN ? (ex_hit & ex_mem_read) : (ex_hit | mem_hit);
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with RAW hazard stalls and
// branch flush.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   freeze              MEM wait: hold every register, stall ID
//   br_taken            branch taken in EX: flush the ID instruction
//   id_*                decoded instruction bundle from the decoder
//   ex_*                registered EX bundle (all zero when a bubble)
//   id_stall            combinational: hold PC and IF/ID this cycle
//   stall_cnt           saturating count of hazard bubbles inserted
//
// Handshake: id_valid marks a real instruction in ID. It is consumed on
// a clock edge where id_stall=0 and br_taken=0; while id_stall=1 the
// upstream stage must present the same instruction again. ex_valid marks
// a real instruction in EX and carries no backpressure.
//
// A shadow MEM slot (valid, dest, wb_en) remembers what left EX last cycle,
// which is all the no-forwarding hazard check needs from MEM.
module id_ex_hazard_reg
    import cpu_pkg::*;
#(
    parameter bit          FORWARD_EN = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              br_taken,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_cmd,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_wb_en,
    input  logic              id_is_imm,
    input  logic              id_is_branch,
    input  logic [1:0]        id_branch_type,
    input  logic [4:0]        id_src1,
    input  logic [4:0]        id_src2,
    input  logic [4:0]        id_dest,
    input  logic              id_uses_src2,
    input  logic [31:0]       id_val1,
    input  logic [31:0]       id_val2,
    input  logic [31:0]       id_imm,
    input  logic [31:0]       id_pc,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_cmd,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_wb_en,
    output logic              ex_is_imm,
    output logic              ex_is_branch,
    output logic [1:0]        ex_branch_type,
    output logic [4:0]        ex_dest,
    output logic [31:0]       ex_val1,
    output logic [31:0]       ex_val2,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_pc,
    output logic              id_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    id_ex_ctrl_t          id_ctrl;
    logic                 hazard;

    logic                 ex_valid_q,  ex_valid_d;
    id_ex_ctrl_t          ex_ctrl_q,   ex_ctrl_d;
    logic [REG_IDX_W-1:0] ex_dest_q,   ex_dest_d;
    logic [DATA_W-1:0]    ex_val1_q,   ex_val1_d;
    logic [DATA_W-1:0]    ex_val2_q,   ex_val2_d;
    logic [DATA_W-1:0]    ex_imm_q,    ex_imm_d;
    logic [DATA_W-1:0]    ex_pc_q,     ex_pc_d;
    logic                 mem_v_q,     mem_v_d;
    logic [REG_IDX_W-1:0] mem_dest_q,  mem_dest_d;
    logic                 mem_wb_q,    mem_wb_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

    assign id_ctrl = '{alu_cmd:     id_alu_cmd,
                       mem_read:    id_mem_read,
                       mem_write:   id_mem_write,
                       wb_en:       id_wb_en,
                       is_imm:      id_is_imm,
                       is_branch:   id_is_branch,
                       branch_type: id_branch_type};

    hazard_detect #(
        .FORWARD_EN (FORWARD_EN)
    ) u_hazard_detect (
        .src1        (id_src1),
        .src2        (id_src2),
        .uses_src2   (id_uses_src2),
        .ex_v        (ex_valid_q),
        .ex_wb       (ex_ctrl_q.wb_en),
        .ex_mem_read (ex_ctrl_q.mem_read),
        .ex_dest     (ex_dest_q),
        .mem_v       (mem_v_q),
        .mem_wb      (mem_wb_q),
        .mem_dest    (mem_dest_q),
        .hazard      (hazard)
    );

    // A flushed instruction is thrown away, so it is not reported as stalled.
    assign id_stall = freeze | (id_valid & ~br_taken & hazard);

    always_comb begin
        // Default: hold everything (this is the freeze behaviour).
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_dest_d   = ex_dest_q;
        ex_val1_d   = ex_val1_q;
        ex_val2_d   = ex_val2_q;
        ex_imm_d    = ex_imm_q;
        ex_pc_d     = ex_pc_q;
        mem_v_d     = mem_v_q;
        mem_dest_d  = mem_dest_q;
        mem_wb_d    = mem_wb_q;
        stall_cnt_d = stall_cnt_q;

        if (!freeze) begin
            // Whatever sits in EX always moves on into the shadow slot.
            mem_v_d    = ex_valid_q;
            mem_dest_d = ex_dest_q;
            mem_wb_d   = ex_ctrl_q.wb_en;

            // Bubble by default; only a clean, valid ID instruction enters.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_dest_d  = '0;
            ex_val1_d  = '0;
            ex_val2_d  = '0;
            ex_imm_d   = '0;
            ex_pc_d    = '0;

            if (br_taken) begin
                // flush: bubble already selected, counter untouched
            end else if (hazard && id_valid) begin
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end else if (id_valid) begin
                ex_valid_d = 1'b1;
                ex_ctrl_d  = id_ctrl;
                ex_dest_d  = id_dest;
                ex_val1_d  = id_val1;
                ex_val2_d  = id_val2;
                ex_imm_d   = id_imm;
                ex_pc_d    = id_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_dest_q   <= '0;
            ex_val1_q   <= '0;
            ex_val2_q   <= '0;
            ex_imm_q    <= '0;
            ex_pc_q     <= '0;
            mem_v_q     <= 1'b0;
            mem_dest_q  <= '0;
            mem_wb_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_dest_q   <= ex_dest_d;
            ex_val1_q   <= ex_val1_d;
            ex_val2_q   <= ex_val2_d;
            ex_imm_q    <= ex_imm_d;
            ex_pc_q     <= ex_pc_d;
            mem_v_q     <= mem_v_d;
            mem_dest_q  <= mem_dest_d;
            mem_wb_q    <= mem_wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_alu_cmd     = ex_ctrl_q.alu_cmd;
    assign ex_mem_read    = ex_ctrl_q.mem_read;
    assign ex_mem_write   = ex_ctrl_q.mem_write;
    assign ex_wb_en       = ex_ctrl_q.wb_en;
    assign ex_is_imm      = ex_ctrl_q.is_imm;
    assign ex_is_branch   = ex_ctrl_q.is_branch;
    assign ex_branch_type = ex_ctrl_q.branch_type;
    assign ex_dest        = ex_dest_q;
    assign ex_val1        = ex_val1_q;
    assign ex_val2        = ex_val2_q;
    assign ex_imm         = ex_imm_q;
    assign ex_pc          = ex_pc_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg. Two instances share one input stream:
// u0 = forwarding, 4-bit counter; u1 = no forwarding, 16-bit counter.
// A reference model per instance predicts id_stall and the next EX bundle.
module tb_id_ex_hazard_reg;
  import cpu_pkg::*;

  localparam int W = 161;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic        mr, mw, wb, imm, br;
    logic [1:0]  bt;
    logic [4:0]  dest;
    logic [31:0] v1, v2, immv, pc;
  } bn_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic        mr, mw, wb, imm, br;
    logic [1:0]  bt;
    logic [4:0]  s1, s2, dest;
    logic        u2;
    logic [31:0] v1, v2, immv, pc;
  } id_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic br_taken = 1'b0;
  id_t  id_cur = '0;

  // DUT outputs
  logic ex_valid_0, ex_mem_read_0, ex_mem_write_0, ex_wb_en_0, ex_is_imm_0, ex_is_branch_0, id_stall_0;
  logic [3:0] ex_alu_cmd_0, stall_cnt_0;
  logic [1:0] ex_branch_type_0;
  logic [4:0] ex_dest_0;
  logic [31:0] ex_val1_0, ex_val2_0, ex_imm_0, ex_pc_0;
  logic ex_valid_1, ex_mem_read_1, ex_mem_write_1, ex_wb_en_1, ex_is_imm_1, ex_is_branch_1, id_stall_1;
  logic [3:0] ex_alu_cmd_1;
  logic [15:0] stall_cnt_1;
  logic [1:0] ex_branch_type_1;
  logic [4:0] ex_dest_1;
  logic [31:0] ex_val1_1, ex_val2_1, ex_imm_1, ex_pc_1;

  id_ex_hazard_reg #(.FORWARD_EN(1'b1), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken),
    .id_valid(id_cur.valid), .id_alu_cmd(id_cur.alu), .id_mem_read(id_cur.mr),
    .id_mem_write(id_cur.mw), .id_wb_en(id_cur.wb), .id_is_imm(id_cur.imm),
    .id_is_branch(id_cur.br), .id_branch_type(id_cur.bt), .id_src1(id_cur.s1),
    .id_src2(id_cur.s2), .id_dest(id_cur.dest), .id_uses_src2(id_cur.u2),
    .id_val1(id_cur.v1), .id_val2(id_cur.v2), .id_imm(id_cur.immv), .id_pc(id_cur.pc),
    .ex_valid(ex_valid_0), .ex_alu_cmd(ex_alu_cmd_0), .ex_mem_read(ex_mem_read_0),
    .ex_mem_write(ex_mem_write_0), .ex_wb_en(ex_wb_en_0), .ex_is_imm(ex_is_imm_0),
    .ex_is_branch(ex_is_branch_0), .ex_branch_type(ex_branch_type_0), .ex_dest(ex_dest_0),
    .ex_val1(ex_val1_0), .ex_val2(ex_val2_0), .ex_imm(ex_imm_0), .ex_pc(ex_pc_0),
    .id_stall(id_stall_0), .stall_cnt(stall_cnt_0)
  );

  id_ex_hazard_reg #(.FORWARD_EN(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken),
    .id_valid(id_cur.valid), .id_alu_cmd(id_cur.alu), .id_mem_read(id_cur.mr),
    .id_mem_write(id_cur.mw), .id_wb_en(id_cur.wb), .id_is_imm(id_cur.imm),
    .id_is_branch(id_cur.br), .id_branch_type(id_cur.bt), .id_src1(id_cur.s1),
    .id_src2(id_cur.s2), .id_dest(id_cur.dest), .id_uses_src2(id_cur.u2),
    .id_val1(id_cur.v1), .id_val2(id_cur.v2), .id_imm(id_cur.immv), .id_pc(id_cur.pc),
    .ex_valid(ex_valid_1), .ex_alu_cmd(ex_alu_cmd_1), .ex_mem_read(ex_mem_read_1),
    .ex_mem_write(ex_mem_write_1), .ex_wb_en(ex_wb_en_1), .ex_is_imm(ex_is_imm_1),
    .ex_is_branch(ex_is_branch_1), .ex_branch_type(ex_branch_type_1), .ex_dest(ex_dest_1),
    .ex_val1(ex_val1_1), .ex_val2(ex_val2_1), .ex_imm(ex_imm_1), .ex_pc(ex_pc_1),
    .id_stall(id_stall_1), .stall_cnt(stall_cnt_1)
  );

  logic [W-1:0] act0, act1;
  assign act0 = {ex_valid_0, ex_alu_cmd_0, ex_mem_read_0, ex_mem_write_0, ex_wb_en_0,
                 ex_is_imm_0, ex_is_branch_0, ex_branch_type_0, ex_dest_0,
                 ex_val1_0, ex_val2_0, ex_imm_0, ex_pc_0, 12'd0, stall_cnt_0};
  assign act1 = {ex_valid_1, ex_alu_cmd_1, ex_mem_read_1, ex_mem_write_1, ex_wb_en_1,
                 ex_is_imm_1, ex_is_branch_1, ex_branch_type_1, ex_dest_1,
                 ex_val1_1, ex_val2_1, ex_imm_1, ex_pc_1, stall_cnt_1};

  // scoreboard
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic         stall_q0[$];
  logic         stall_q1[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // reference model: EX holds the last accepted instruction, MEM what left EX
  bn_t  m_ex[2];
  logic m_mv[2];
  logic [4:0] m_md[2];
  logic m_mwb[2];
  int   m_cnt[2];
  logic m_stall[2];
  int   active = 0;

  function automatic logic reads(input id_t i, input logic [4:0] d);
    return (d != 5'd0) && (i.s1 == d || (i.u2 && i.s2 == d));
  endfunction

  function automatic bn_t to_bundle(input id_t i);
    bn_t b;
    b = '0;
    if (i.valid) begin
      b.valid = 1'b1; b.alu = i.alu; b.mr = i.mr; b.mw = i.mw; b.wb = i.wb;
      b.imm = i.imm; b.br = i.br; b.bt = i.bt; b.dest = i.dest;
      b.v1 = i.v1; b.v2 = i.v2; b.immv = i.immv; b.pc = i.pc;
    end
    return b;
  endfunction

  task automatic model_eval(input int k);
    logic haz;
    int   cmax;
    logic fwd;
    fwd  = (k == 0);
    cmax = (k == 0) ? 15 : 65535;
    haz  = 1'b0;
    if (m_ex[k].valid && m_ex[k].wb && (!fwd || m_ex[k].mr) && reads(id_cur, m_ex[k].dest)) haz = 1'b1;
    if (!fwd && m_mv[k] && m_mwb[k] && reads(id_cur, m_md[k])) haz = 1'b1;
    m_stall[k] = freeze | (id_cur.valid & ~br_taken & haz);
    if (rst) begin
      m_ex[k] = '0; m_mv[k] = 1'b0; m_md[k] = '0; m_mwb[k] = 1'b0; m_cnt[k] = 0;
    end else if (!freeze) begin
      m_mv[k] = m_ex[k].valid; m_md[k] = m_ex[k].dest; m_mwb[k] = m_ex[k].wb;
      if (br_taken) m_ex[k] = '0;
      else if (haz && id_cur.valid) begin
        m_ex[k] = '0;
        if (m_cnt[k] < cmax) m_cnt[k]++;
      end else m_ex[k] = to_bundle(id_cur);
    end
    if (k == 0) begin
      stall_q0.push_back(m_stall[k]);
      exp_q0.push_back({m_ex[k], 16'(m_cnt[k])});
    end else begin
      stall_q1.push_back(m_stall[k]);
      exp_q1.push_back({m_ex[k], 16'(m_cnt[k])});
    end
  endtask

  // monitors
  initial forever begin
    logic e;
    @(negedge clk); #3;
    if (stall_q0.size() > 0) begin e = stall_q0.pop_front(); chk("id_stall_u0", 32'(id_stall_0), 32'(e)); end
    if (stall_q1.size() > 0) begin e = stall_q1.pop_front(); chk("id_stall_u1", 32'(id_stall_1), 32'(e)); end
  end

  initial forever begin
    logic [W-1:0] e;
    @(posedge clk); #1;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); total++;
      if (act0 !== e) begin bad++; $display("FAIL ex_bundle_u0: got %h expected %h", act0, e); end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front(); total++;
      if (act1 !== e) begin bad++; $display("FAIL ex_bundle_u1: got %h expected %h", act1, e); end
    end
  end

  // driver tasks
  task automatic step();
    #1;
    model_eval(0);
    model_eval(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; id_cur = '0;
    step();
    rst = 1'b0;
  endtask

  function automatic id_t mk(input logic [3:0] alu, input logic mr, input logic wb,
                             input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                             input logic [4:0] dest);
    id_t i;
    i = '0;
    i.valid = 1'b1; i.alu = alu; i.mr = mr; i.wb = wb; i.imm = ~u2;
    i.s1 = s1; i.s2 = s2; i.u2 = u2; i.dest = dest;
    i.v1 = $urandom; i.v2 = $urandom; i.immv = $urandom; i.pc = $urandom;
    return i;
  endfunction

  // present an instruction, holding it while the active instance's model stalls
  task automatic issue(input id_t ins);
    int guard;
    guard = 0;
    id_cur = ins;
    step();
    while (m_stall[active] && guard < 20) begin step(); guard++; end
    if (guard >= 20) begin
      total++; bad++;
      $display("FAIL issue_timeout: got %0d stalls expected < 20", guard);
    end
    id_cur = '0;
  endtask

  id_t tmp;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mv[k] = 0; m_md[k] = '0; m_mwb[k] = 0; m_cnt[k] = 0; m_stall[k] = 0;
    end
    @(negedge clk);
    step();
    rst = 1'b0;

    // reset mid-stream
    issue(mk(ALU_ADD, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd5));
    chk("add_in_ex_valid", 32'(ex_valid_0), 32'd1);
    chk("add_in_ex_dest", 32'(ex_dest_0), 32'd5);
    do_reset();
    chk("rst_ex_valid", 32'(ex_valid_0), 32'd0);
    chk("rst_ex_dest", 32'(ex_dest_0), 32'd0);
    chk("rst_ex_val1", ex_val1_1, 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt_0), 32'd0);
    chk("rst_id_stall", 32'(id_stall_0), 32'd0);

    // load-use with forwarding: one bubble
    active = 0;
    issue(mk(ALU_ADD, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd3));
    issue(mk(ALU_ADD, 1'b0, 1'b1, 5'd3, 5'd1, 1'b1, 5'd4));
    chk("lu_stall_cnt", 32'(stall_cnt_0), 32'd1);
    chk("lu_ex_valid", 32'(ex_valid_0), 32'd1);
    chk("lu_ex_dest", 32'(ex_dest_0), 32'd4);

    // no forwarding: back-to-back dependence costs two bubbles
    do_reset();
    active = 1;
    issue(mk(ALU_SUB, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd7));
    issue(mk(ALU_OR,  1'b0, 1'b1, 5'd7, 5'd2, 1'b1, 5'd8));
    chk("nf_stall_cnt", 32'(stall_cnt_1), 32'd2);
    chk("nf_ex_dest", 32'(ex_dest_1), 32'd8);
    chk("fw_no_stall", 32'(stall_cnt_0), 32'd0);
    issue(mk(ALU_ADD, 1'b0, 1'b1, 5'd1, 5'd1, 1'b1, 5'd0));
    issue(mk(ALU_ADD, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd9));
    chk("r0_no_stall", 32'(stall_cnt_1), 32'd2);
    chk("r0_ex_dest", 32'(ex_dest_1), 32'd9);

    // branch flush beats hazard; shadow takes the branch (wb_en=0)
    do_reset();
    active = 1;
    issue(mk(ALU_SUB, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd7));
    tmp = mk(ALU_ADD, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 5'd0);
    tmp.br = 1'b1; tmp.bt = BR_BEZ;
    issue(tmp);
    id_cur = mk(ALU_OR, 1'b0, 1'b1, 5'd7, 5'd2, 1'b1, 5'd8);
    br_taken = 1'b1;
    #1;
    chk("flush_id_stall", 32'(id_stall_1), 32'd0);
    step();
    br_taken = 1'b0;
    chk("flush_ex_valid", 32'(ex_valid_1), 32'd0);
    chk("flush_stall_cnt", 32'(stall_cnt_1), 32'd0);
    issue(mk(ALU_OR, 1'b0, 1'b1, 5'd7, 5'd2, 1'b1, 5'd8));
    chk("after_flush_cnt", 32'(stall_cnt_1), 32'd0);
    chk("after_flush_dest", 32'(ex_dest_1), 32'd8);

    // freeze beats branch
    do_reset();
    active = 1;
    issue(mk(ALU_SUB, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd7));
    freeze = 1'b1; br_taken = 1'b1;
    id_cur = mk(ALU_OR, 1'b0, 1'b1, 5'd7, 5'd2, 1'b1, 5'd8);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("frz_id_stall_u1", 32'(id_stall_1), 32'd1);
      chk("frz_id_stall_u0", 32'(id_stall_0), 32'd1);
      step();
      chk("frz_ex_valid", 32'(ex_valid_1), 32'd1);
      chk("frz_ex_dest", 32'(ex_dest_1), 32'd7);
      chk("frz_stall_cnt", 32'(stall_cnt_1), 32'd0);
    end
    freeze = 1'b0;
    step();
    chk("unfrz_flush", 32'(ex_valid_1), 32'd0);
    br_taken = 1'b0; id_cur = '0;

    // saturation of the 4-bit counter
    do_reset();
    active = 0;
    for (int n = 0; n < 20; n++) begin
      issue(mk(ALU_ADD, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd3));
      issue(mk(ALU_ADD, 1'b0, 1'b1, 5'd3, 5'd1, 1'b1, 5'd4));
    end
    chk("sat_stall_cnt", 32'(stall_cnt_0), 32'hF);

    // random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      id_cur = mk(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)));
      id_cur.valid = ($urandom_range(0, 3) != 0);
      id_cur.mw = 1'($urandom_range(0, 1));
      id_cur.br = 1'($urandom_range(0, 1));
      id_cur.bt = 2'($urandom_range(0, 2));
      freeze   = ($urandom_range(0, 7) == 0);
      br_taken = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; id_cur = '0;
    step();
    @(posedge clk); #2;
    chk("drain_u0", exp_q0.size(), 32'd0);
    chk("drain_u1", exp_q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
